// File: rtl/load_store_unit.sv
// RV32I load/store stage: one bus access at a time, byte-lane formatting and alignment checks.
// Optional bus-ready watchdog is compiled in with `define LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata_out,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ready
);

  typedef enum logic [1:0] {IDLE, CHECK, REQ, DONE} state_t;

  // Bus handshake: bus_req rises with address/data/enables already valid and all of
  // them hold unchanged until the first cycle that samples bus_ready = 1, which ends the transfer.
  state_t state;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [31:0]       wdata_q;
  logic              rd_q;
  logic              wr_q;

  logic        misaligned;
  logic        illegal;
  logic [1:0]  off;
  logic [3:0]  store_be;
  logic [31:0] store_data;
  logic [15:0] lane;
  logic [31:0] load_val;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;
`endif

  assign off = addr_q[1:0];

  always_comb begin
    misaligned = 1'b0;
    case (f3_q[1:0])
      2'b01:   misaligned = addr_q[0];
      2'b10:   misaligned = (addr_q[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase

    if (wr_q) illegal = (f3_q > 3'b010);
    else      illegal = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111);

    case (f3_q[1:0])
      2'b00:   begin store_be = 4'b0001 << off; store_data = {4{wdata_q[7:0]}};  end
      2'b01:   begin store_be = 4'b0011 << off; store_data = {2{wdata_q[15:0]}}; end
      default: begin store_be = 4'b1111;        store_data = wdata_q;            end
    endcase

    // Only the low 16 bits of the shifted word are ever needed for sub-word loads.
    lane = 16'(bus_rdata >> {off, 3'b000});
    case (f3_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'h0, lane[7:0]};
      3'b101:  load_val = {16'h0, lane[15:0]};
      default: load_val = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      f3_q      <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      rdata_out <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
`ifdef LSU_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          if (start) begin
            addr_q  <= addr;
            f3_q    <= funct3;
            wdata_q <= wdata;
            rd_q    <= mem_read;
            wr_q    <= mem_write;
            busy    <= 1'b1;
            state   <= CHECK;
          end
        end

        CHECK: begin
          if (!rd_q && !wr_q) begin
            done  <= 1'b1;
            fault <= 1'b0;
            state <= DONE;
          end else if (illegal || misaligned) begin
            done  <= 1'b1;
            fault <= 1'b1;
            state <= DONE;
          end else begin
            bus_req   <= 1'b1;
            bus_we    <= wr_q;
            bus_addr  <= {addr_q[ADDR_W-1:2], 2'b00};
            bus_be    <= wr_q ? store_be : 4'b1111;
            bus_wdata <= wr_q ? store_data : 32'h0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
            state     <= REQ;
          end
        end

        REQ: begin
          if (bus_ready) begin
            if (!wr_q) rdata_out <= load_val;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            done      <= 1'b1;
            fault     <= 1'b0;
            state     <= DONE;
          end
`ifdef LSU_TIMEOUT_EN
          // Ready on the limit cycle already took the branch above.
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            done      <= 1'b1;
            fault     <= 1'b1;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        DONE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, stalls, reset and optional watchdog.
module tb_load_store_unit;

  logic        clk, rst, start, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, fault;
  logic [31:0] rdata_out;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ready;

  int errors = 0;
  int checks = 0;

  // Observations from the most recent access.
  logic        seen_req, unstable, got_fault, timed_out;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_we;
  int          req_cycles, lat;

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done), .fault(fault),
    .rdata_out(rdata_out), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and follow it to done; ready is raised after `delay` stalled REQ cycles.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdv,
                        input int delay, input logic poke_en);
    int waited;
    logic fin;
    seen_req = 0; unstable = 0; got_fault = 0; timed_out = 0;
    req_cycles = 0; lat = 0; waited = 0; fin = 0;
    req_addr = 0; req_wdata = 0; req_be = 0; req_we = 0;
    bus_ready = 1'b0;
    bus_rdata = rdv;
    @(posedge clk); #1;
    start = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b111; addr = 32'hDEAD_BEE3; wdata = 32'h5555_5555;
    while (!fin && lat < 300) begin
      if (start) begin start = 1'b0; mem_read = 1'b0; end
      if (done) begin
        got_fault = fault;
        fin = 1'b1;
        bus_ready = 1'b0;
      end else begin
        if (bus_req) begin
          if (!seen_req) begin
            req_addr = bus_addr; req_wdata = bus_wdata; req_be = bus_be; req_we = bus_we;
          end else if (bus_addr !== req_addr || bus_wdata !== req_wdata ||
                       bus_be !== req_be || bus_we !== req_we) begin
            unstable = 1'b1;
          end
          seen_req = 1'b1;
          req_cycles++;
          if (waited == delay) bus_ready = 1'b1;
          else waited++;
          if (poke_en && req_cycles == 2) begin
            start = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0010;
          end
        end
        @(posedge clk); #1;
        lat++;
      end
    end
    if (!fin) timed_out = 1'b1;
    bus_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
    checks++; if (rdata_out !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata_out); end
    checks++; if ({done, fault, bus_we, bus_be, bus_addr, bus_wdata} !== '0) begin
      errors++; $display("FAIL reset_misc: got done=%b fault=%b we=%b be=%b want all 0", done, fault, bus_we, bus_be);
    end
    rst = 1'b0;
  endtask

  task automatic test_load;
    access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 1'b0);
    checks++; if (req_addr !== 32'h0000_1000) begin errors++; $display("FAIL lb_addr: got %h want 00001000", req_addr); end
    checks++; if (req_be !== 4'b1111 || req_we !== 1'b0) begin errors++; $display("FAIL lb_be_we: got %b/%b want 1111/0", req_be, req_we); end
    checks++; if (rdata_out !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", rdata_out); end
    checks++; if (got_fault !== 1'b0) begin errors++; $display("FAIL lb_fault: got %b want 0", got_fault); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL lb_latency: got %0d want 2", lat); end

    access(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h1122_3344, 0, 1'b0);
    checks++; if (rdata_out !== 32'h1122_3344) begin errors++; $display("FAIL lw_data: got %h want 11223344", rdata_out); end

    access(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0, 1'b0);
    checks++; if (rdata_out !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_data: got %h want 0000beef", rdata_out); end

    access(1'b1, 1'b0, 3'b100, 32'h0000_2002, 32'h0, 32'h00A5_0000, 0, 1'b0);
    checks++; if (rdata_out !== 32'h0000_00A5) begin errors++; $display("FAIL lbu_data: got %h want 000000a5", rdata_out); end

    access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0, 1'b0);
    checks++; if (rdata_out !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_data: got %h want ffffbeef", rdata_out); end
  endtask

  task automatic test_store;
    access(1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h1234_56AB, 32'hFFFF_FFFF, 0, 1'b0);
    checks++; if (req_we !== 1'b1 || req_be !== 4'b0010) begin errors++; $display("FAIL sb_we_be: got %b/%b want 1/0010", req_we, req_be); end
    checks++; if (req_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h want abababab", req_wdata); end
    checks++; if (rdata_out !== 32'hFFFF_BEEF) begin errors++; $display("FAIL sb_rdata_hold: got %h want ffffbeef", rdata_out); end

    access(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h1234_56AB, 32'h0, 0, 1'b0);
    checks++; if (req_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b want 1100", req_be); end
    checks++; if (req_wdata !== 32'h56AB_56AB) begin errors++; $display("FAIL sh_wdata: got %h want 56ab56ab", req_wdata); end
    checks++; if (req_addr !== 32'h0000_3000) begin errors++; $display("FAIL sh_addr: got %h want 00003000", req_addr); end
  endtask

  task automatic test_fault;
    access(1'b1, 1'b0, 3'b010, 32'h0000_4002, 32'h0, 32'h0, 0, 1'b0);
    checks++; if (seen_req !== 1'b0 || got_fault !== 1'b1) begin errors++; $display("FAIL lw_misaligned: got req=%b fault=%b want 0/1", seen_req, got_fault); end
    checks++; if (rdata_out !== 32'hFFFF_BEEF) begin errors++; $display("FAIL fault_rdata_hold: got %h want ffffbeef", rdata_out); end

    access(1'b0, 1'b1, 3'b001, 32'h0000_3003, 32'h0, 32'h0, 0, 1'b0);
    checks++; if (seen_req !== 1'b0 || got_fault !== 1'b1) begin errors++; $display("FAIL sh_misaligned: got req=%b fault=%b want 0/1", seen_req, got_fault); end

    access(1'b1, 1'b0, 3'b011, 32'h0000_4000, 32'h0, 32'h0, 0, 1'b0);
    checks++; if (seen_req !== 1'b0 || got_fault !== 1'b1) begin errors++; $display("FAIL load_illegal: got req=%b fault=%b want 0/1", seen_req, got_fault); end

    access(1'b1, 1'b1, 3'b100, 32'h0000_4000, 32'h0, 32'h0, 0, 1'b0);
    checks++; if (seen_req !== 1'b0 || got_fault !== 1'b1) begin errors++; $display("FAIL store_illegal: got req=%b fault=%b want 0/1", seen_req, got_fault); end

    access(1'b0, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 0, 1'b0);
    checks++; if (seen_req !== 1'b0 || got_fault !== 1'b0 || timed_out !== 1'b0) begin
      errors++; $display("FAIL no_op: got req=%b fault=%b timeout=%b want 0/0/0", seen_req, got_fault, timed_out);
    end
  endtask

  task automatic test_back_to_back;
    access(1'b0, 1'b1, 3'b010, 32'h0000_5004, 32'hCAFE_F00D, 32'h0, 5, 1'b1);
    checks++; if (req_cycles !== 6) begin errors++; $display("FAIL sw_req_cycles: got %0d want 6", req_cycles); end
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL sw_stable: got unstable=%b want 0", unstable); end
    checks++; if (req_wdata !== 32'hCAFE_F00D || req_be !== 4'b1111 || req_addr !== 32'h0000_5004) begin
      errors++; $display("FAIL sw_bus: got %h/%b/%h want cafef00d/1111/00005004", req_wdata, req_be, req_addr);
    end
    checks++; if (got_fault !== 1'b0) begin errors++; $display("FAIL sw_fault: got %b want 0", got_fault); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sw_idle: got busy=%b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL ignored_start: got busy=%b req=%b want 0/0", busy, bus_req); end
  endtask

  task automatic test_reset_mid;
    int n;
    bus_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_6000;
    @(posedge clk); #1;
    start = 1'b0; mem_read = 1'b0;
    n = 0;
    while (!bus_req && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL mid_req_reached: got %b want 1", bus_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL async_reset: got req=%b busy=%b done=%b want 0/0/0", bus_req, busy, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    access(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'h1357_9BDF, 0, 1'b0);
    checks++; if (rdata_out !== 32'h1357_9BDF || got_fault !== 1'b0) begin
      errors++; $display("FAIL after_reset_lw: got %h fault=%b want 13579bdf/0", rdata_out, got_fault);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    access(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 32'h0, 1000, 1'b0);
    checks++; if (timed_out !== 1'b0 || got_fault !== 1'b1) begin
      errors++; $display("FAIL timeout_fault: got hang=%b fault=%b want 0/1", timed_out, got_fault);
    end
    checks++; if (req_cycles !== 4) begin errors++; $display("FAIL timeout_cycles: got %0d want 4", req_cycles); end
    checks++; if (rdata_out !== 32'h1357_9BDF) begin errors++; $display("FAIL timeout_rdata: got %h want 13579bdf", rdata_out); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0; bus_rdata = 32'h0; bus_ready = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_fault();
    test_back_to_back();
    test_reset_mid();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU in the RISC-V core. It takes the ALU result as the effective address and performs RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a single-outstanding request/ready bus to data RAM and the peripheral space. It formats byte enables and store data, sign- or zero-extends load data, and flags misaligned or illegal accesses without issuing a bus transaction.

Parameters:
ADDR_W, 32, bus address width; upper bits of addr are passed through unchanged.
TIMEOUT_CYCLES, 255, bus-ready watchdog limit; used only when LSU_TIMEOUT_EN is defined.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request from execute; accepted only in IDLE
mem_read  input  1  load request qualifier
mem_write  input  1  store request qualifier; wins if both are set
funct3  input  3  RV32I width/sign code
addr  input  ADDR_W  effective address (ALU result)
wdata  input  32  store data (rs2)
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle completion pulse
fault  output  1  valid with done: access aborted
rdata_out  output  32  formatted load result
bus_req  output  1  bus request, held until accepted
bus_we  output  1  1 = write
bus_addr  output  ADDR_W  word-aligned address (addr with [1:0] = 0)
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated store data
bus_rdata  input  32  read data, valid when bus_ready = 1
bus_ready  input  1  transfer complete this cycle

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset is asynchronous; bus_req drops immediately, including mid-transfer, and any in-flight result is discarded.
- States and transitions:
  - IDLE --start--> CHECK.
  - CHECK: always one cycle. Illegal or misaligned access goes to DONE with fault = 1. Neither mem_read nor mem_write set goes to DONE with fault = 0 and no bus access. Otherwise goes to REQ.
  - REQ: bus_req = 1. On a cycle with bus_ready = 1, go to DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- busy = 1 in CHECK, REQ and DONE. A start received while busy is ignored.
- addr, funct3, wdata, mem_read and mem_write are registered on the accepted start. Bus outputs stay stable throughout REQ.
- Minimum latency: start at edge N gives done high in cycle N+3 when bus_ready is already high in the first REQ cycle.
- Misaligned access:
  - Halfword (funct3 = 001 or 101) with addr[0] = 1.
  - Word (010) with addr[1:0] != 0.
- Illegal funct3: loads 011, 110, 111; stores above 010.
- Store formatting:
  - SB: bus_be = 0001 << addr[1:0]; bus_wdata = wdata[7:0] replicated into all 4 lanes.
  - SH: bus_be = 0011 << addr[1:0]; bus_wdata = wdata[15:0] replicated into both halves.
  - SW: bus_be = 1111.
- Load formatting:
  - bus_be = 1111.
  - Lane = bus_rdata >> (8 × addr[1:0]).
  - LB/LH: sign-extend; LBU/LHU: zero-extend; LW: pass through.
  - Captured into rdata_out on the bus_ready edge.
- rdata_out holds its value across stores, faults and idle cycles; it updates only on a completed load.
- bus_rdata is ignored when bus_we = 1.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: an 8-bit-or-wider counter clears on entry to REQ and increments on each REQ cycle with bus_ready = 0.
  - Reaching TIMEOUT_CYCLES drops bus_req and goes to DONE with fault = 1; rdata_out is unchanged.
  - bus_ready arriving in the same cycle as the limit wins: normal completion, fault = 0.
- Undefined: no counter exists, and REQ waits for bus_ready indefinitely.

Test Plan:
- LB at addr 0x1003, bus_rdata 0x80FF_1234, ready in first REQ cycle -> bus_addr 0x1000, bus_be 1111, rdata_out 0xFFFF_FF80, done in cycle N+3, fault 0.
- LHU at 0x2002 with bus_rdata 0xBEEF_0000 -> rdata_out 0x0000_BEEF. LH at the same address -> 0xFFFF_BEEF.
- SB wdata 0x1234_56AB at 0x3001 -> bus_we 1, bus_be 0010, bus_wdata 0xABAB_ABAB. SH at 0x3002 -> bus_be 1100, bus_wdata 0x56AB_56AB.
- LW at 0x4002 -> no bus_req ever; done with fault 1; rdata_out unchanged.
- SW with bus_ready delayed 5 cycles -> bus_req, bus_addr and bus_wdata held stable for 6 cycles; a second start pulsed during the wait is ignored.
- Reset asserted mid-REQ -> bus_req, busy and done go 0 immediately. With LSU_TIMEOUT_EN defined and TIMEOUT_CYCLES = 4, ready never asserted -> fault 1 after 4 wait cycles.
